// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: PC sequencing, shared imem port (boot loader / run-time fetch),
// stall, redirect and halt handling. Optional counters are built when FETCH_PERF_EN is defined.
module fetch_sequencer #(
  parameter int                 DATA_W     = 32,
  parameter int                 IMEM_DEPTH = 32,
  parameter logic [DATA_W-1:0]  RESET_PC   = {DATA_W{1'b0}},
  parameter logic [DATA_W-1:0]  HALT_WORD  = {DATA_W{1'b1}},
  localparam int                ADDR_W     = $clog2(IMEM_DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              boot_we,
  input  logic [ADDR_W-1:0] boot_addr,
  input  logic [DATA_W-1:0] boot_data,
  input  logic              boot_done,
  input  logic              pcsrc,
  input  logic [DATA_W-1:0] branch_target,
  input  logic              stall,
  input  logic [DATA_W-1:0] instr_in,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_we,
  output logic [DATA_W-1:0] imem_wdata,
  output logic [DATA_W-1:0] pc,
  output logic [DATA_W-1:0] adder_output,
  output logic [DATA_W-1:0] instruction,
  output logic              if_valid,
  output logic              halted
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_bubbles
`endif
);

  localparam logic [DATA_W-1:0] PC_ONE = {{(DATA_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_BOOT    = 2'd0,
    ST_RUN     = 2'd1,
    ST_HALT    = 2'd2,
    ST_ILLEGAL = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] adder_q, adder_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic              valid_q, valid_d;
  logic              halted_q, halted_d;
  logic              fetch_s;
  logic              bubble_s;

  // Next-state and datapath decisions; redirect beats stall beats halt beats sequential fetch.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    adder_d  = adder_q;
    instr_d  = instr_q;
    valid_d  = valid_q;
    fetch_s  = 1'b0;
    bubble_s = 1'b0;
    case (state_q)
      ST_BOOT: begin
        valid_d = 1'b0;
        if (boot_done) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_BOOT;
        end
      end
      ST_RUN: begin
        if (pcsrc) begin
          // Squash the word currently addressed; it belongs to the wrong path.
          pc_d     = branch_target;
          instr_d  = {DATA_W{1'b0}};
          valid_d  = 1'b0;
          bubble_s = 1'b1;
        end else if (stall) begin
          bubble_s = 1'b1;
        end else if (instr_in == HALT_WORD) begin
          instr_d = instr_in;
          adder_d = pc_q + PC_ONE;
          valid_d = 1'b1;
          fetch_s = 1'b1;
          state_d = ST_HALT;
        end else begin
          instr_d = instr_in;
          adder_d = pc_q + PC_ONE;
          pc_d    = pc_q + PC_ONE;
          valid_d = 1'b1;
          fetch_s = 1'b1;
        end
      end
      ST_HALT: begin
        valid_d = 1'b0;
      end
      default: begin
        state_d = ST_BOOT;
        valid_d = 1'b0;
      end
    endcase
    halted_d = (state_d == ST_HALT);
  end

  // Fetch-stage state and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_BOOT;
      pc_q     <= RESET_PC;
      adder_q  <= RESET_PC + PC_ONE;
      instr_q  <= {DATA_W{1'b0}};
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      adder_q  <= adder_d;
      instr_q  <= instr_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
    end
  end

  // imem port ownership: the loader drives it in BOOT, the PC drives it otherwise.
  always_comb begin
    if (state_q == ST_BOOT) begin
      imem_addr  = boot_addr;
      imem_we    = boot_we;
      imem_wdata = boot_data;
    end else begin
      imem_addr  = pc_q[ADDR_W-1:0];
      imem_we    = 1'b0;
      imem_wdata = {DATA_W{1'b0}};
    end
  end

  assign pc           = pc_q;
  assign adder_output = adder_q;
  assign instruction  = instr_q;
  assign if_valid     = valid_q;
  assign halted       = halted_q;

`ifdef FETCH_PERF_EN
  logic [31:0] fetched_q, bubbles_q;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    if (v == 32'hFFFF_FFFF) begin
      return v;
    end else begin
      return v + 32'd1;
    end
  endfunction

  // Performance counters; fetch_s/bubble_s are only raised in RUN so BOOT/HALT freeze them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetched_q <= 32'd0;
      bubbles_q <= 32'd0;
    end else begin
      if (fetch_s) begin
        fetched_q <= sat_inc(fetched_q);
      end else begin
        fetched_q <= fetched_q;
      end
      if (bubble_s) begin
        bubbles_q <= sat_inc(bubbles_q);
      end else begin
        bubbles_q <= bubbles_q;
      end
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_bubbles = bubbles_q;
`else
  logic unused_perf_s;
  assign unused_perf_s = fetch_s ^ bubble_s;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: behavioural fetch model checked every negedge, plus literal checkpoints.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        boot_we;
  logic [4:0]  boot_addr;
  logic [31:0] boot_data;
  logic        boot_done;
  logic        pcsrc;
  logic [31:0] branch_target;
  logic        stall;
  logic [31:0] instr_in;
  logic [4:0]  imem_addr;
  logic        imem_we;
  logic [31:0] imem_wdata;
  logic [31:0] pc, adder_output, instruction;
  logic        if_valid, halted;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_bubbles;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  fetch_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .boot_we(boot_we), .boot_addr(boot_addr), .boot_data(boot_data), .boot_done(boot_done),
    .pcsrc(pcsrc), .branch_target(branch_target), .stall(stall), .instr_in(instr_in),
    .imem_addr(imem_addr), .imem_we(imem_we), .imem_wdata(imem_wdata),
    .pc(pc), .adder_output(adder_output), .instruction(instruction),
    .if_valid(if_valid), .halted(halted)
`ifdef FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_bubbles(perf_bubbles)
`endif
  );

  always #5 clk = ~clk;

  // Physical instruction memory driven by the DUT's port.
  logic [31:0] tb_mem [32];
  always @(posedge clk) if (imem_we) tb_mem[imem_addr] <= imem_wdata;
  assign instr_in = tb_mem[imem_addr];

  function automatic logic [31:0] image(input int a);
    case (a)
      0: return 32'h11;
      1: return 32'h22;
      2: return 32'h33;
      3: return 32'hFFFF_FFFF;
      5: return 32'h55;
      6: return 32'h66;
      default: return 32'h100 + a;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: mode 0 boot, 1 run, 2 halt; own copy of memory contents.
  int          m_mode;
  logic [31:0] m_pc, m_add, m_ins, m_fet, m_bub, w;
  logic        m_val;
  logic [31:0] m_mem [32];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_pc = 32'd0; m_add = 32'd1; m_ins = 32'd0; m_val = 1'b0;
      m_fet = 32'd0; m_bub = 32'd0;
    end else if (m_mode == 0) begin
      if (boot_we) m_mem[boot_addr] = boot_data;
      if (boot_done) m_mode = 1;
      m_val = 1'b0;
    end else if (m_mode == 1) begin
      if (pcsrc || stall) m_bub = (m_bub == 32'hFFFF_FFFF) ? m_bub : m_bub + 32'd1;
      if (pcsrc) begin
        m_pc = branch_target; m_ins = 32'd0; m_val = 1'b0;
      end else if (!stall) begin
        w = m_mem[m_pc % 32];
        m_ins = w; m_add = m_pc + 32'd1; m_val = 1'b1;
        m_fet = (m_fet == 32'hFFFF_FFFF) ? m_fet : m_fet + 32'd1;
        if (w == 32'hFFFF_FFFF) m_mode = 2;
        else m_pc = m_pc + 32'd1;
      end
    end else begin
      m_val = 1'b0;
    end
  end

  // Compare process: every negedge, all outputs against the model.
  always @(negedge clk) begin
    chk("pc", pc, m_pc);
    chk("adder_output", adder_output, m_add);
    chk("instruction", instruction, m_ins);
    chk("if_valid", {31'd0, if_valid}, {31'd0, m_val});
    chk("halted", {31'd0, halted}, {31'd0, m_mode == 2});
    chk("imem_addr", {27'd0, imem_addr}, (m_mode == 0) ? {27'd0, boot_addr} : (m_pc % 32));
    chk("imem_we", {31'd0, imem_we}, (m_mode == 0) ? {31'd0, boot_we} : 32'd0);
    chk("imem_wdata", imem_wdata, (m_mode == 0) ? boot_data : 32'd0);
`ifdef FETCH_PERF_EN
    chk("perf_fetched", perf_fetched, m_fet);
    chk("perf_bubbles", perf_bubbles, m_bub);
`endif
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string nm, input logic [31:0] epc, input logic [31:0] eadd,
                         input logic [31:0] eins, input logic ev, input logic eh);
    chk({nm, ".pc"}, pc, epc);
    chk({nm, ".adder"}, adder_output, eadd);
    chk({nm, ".instr"}, instruction, eins);
    chk({nm, ".valid"}, {31'd0, if_valid}, {31'd0, ev});
    chk({nm, ".halted"}, {31'd0, halted}, {31'd0, eh});
  endtask

  initial begin
    rst_n = 1'b0; boot_we = 1'b0; boot_addr = 5'd0; boot_data = 32'd0; boot_done = 1'b0;
    pcsrc = 1'b0; branch_target = 32'd0; stall = 1'b0;
    cyc(); cyc();
    chk_out("reset", 32'd0, 32'd1, 32'd0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // Boot fill of the whole memory image.
    for (int a = 0; a < 32; a++) begin
      boot_we = 1'b1; boot_addr = a[4:0]; boot_data = image(a);
      cyc();
    end
    boot_we = 1'b0; boot_done = 1'b1;
    cyc();
    boot_done = 1'b0;
    chk("boot_exit.pc", pc, 32'd0);
    chk("boot_exit.imem_we", {31'd0, imem_we}, 32'd0);

    cyc(); chk_out("seq0", 32'd1, 32'd1, 32'h11, 1'b1, 1'b0);
    chk("model_pin_seq0", m_ins, 32'h11);
    cyc(); chk_out("seq1", 32'd2, 32'd2, 32'h22, 1'b1, 1'b0);

    stall = 1'b1;
    cyc(); chk_out("stall0", 32'd2, 32'd2, 32'h22, 1'b1, 1'b0);
    cyc(); chk_out("stall1", 32'd2, 32'd2, 32'h22, 1'b1, 1'b0);
    stall = 1'b0;
    cyc(); chk_out("resume", 32'd3, 32'd3, 32'h33, 1'b1, 1'b0);

    pcsrc = 1'b1; stall = 1'b1; branch_target = 32'd5;
    cyc(); chk_out("redir", 32'd5, 32'd3, 32'd0, 1'b0, 1'b0);
    chk("model_pin_redir", m_pc, 32'd5);
    pcsrc = 1'b0; stall = 1'b0;
    cyc(); chk_out("redir_next", 32'd6, 32'd6, 32'h55, 1'b1, 1'b0);

    pcsrc = 1'b1; branch_target = 32'd33;
    cyc(); chk("alias.pc", pc, 32'd33); chk("alias.addr", {27'd0, imem_addr}, 32'd1);
    pcsrc = 1'b0;
    cyc(); chk_out("alias_next", 32'd34, 32'd34, 32'h22, 1'b1, 1'b0);

    pcsrc = 1'b1; branch_target = 32'hFFFF_FFFF;
    cyc(); chk("wrap.pc", pc, 32'hFFFF_FFFF);
    pcsrc = 1'b0;
    cyc(); chk_out("wrap_next", 32'd0, 32'd0, 32'h11F, 1'b1, 1'b0);
    chk("model_pin_wrap", m_add, 32'd0);

    pcsrc = 1'b1; branch_target = 32'd3;
    cyc();
    pcsrc = 1'b0;
    cyc(); chk("halt_issue.instr", instruction, 32'hFFFF_FFFF);
    chk("halt_issue.valid", {31'd0, if_valid}, 32'd1);
    chk("halt_issue.pc", pc, 32'd3);
    cyc(); chk_out("halted", 32'd3, 32'd4, 32'hFFFF_FFFF, 1'b0, 1'b1);

    pcsrc = 1'b1; stall = 1'b1; branch_target = 32'd7;
    boot_we = 1'b1; boot_addr = 5'd3; boot_data = 32'd0; boot_done = 1'b1;
    chk("halt.imem_we", {31'd0, imem_we}, 32'd0);
    cyc(); pcsrc = 1'b0;
    cyc(); chk_out("halt_frozen", 32'd3, 32'd4, 32'hFFFF_FFFF, 1'b0, 1'b1);
    boot_we = 1'b0; boot_done = 1'b0; stall = 1'b0;

    // Reboot, run, then an asynchronous reset between clock edges.
    rst_n = 1'b0; cyc(); cyc();
    rst_n = 1'b1; boot_done = 1'b1;
    cyc(); boot_done = 1'b0;
    cyc(); cyc();
    chk("pre_reset.pc", pc, 32'd2);
    #2;
    rst_n = 1'b0; boot_we = 1'b1; boot_addr = 5'd9; boot_data = 32'hABCD;
    #1;
    chk_out("async_reset", 32'd0, 32'd1, 32'd0, 1'b0, 1'b0);
    chk("async_reset.imem_we", {31'd0, imem_we}, 32'd1);
    chk("async_reset.imem_addr", {27'd0, imem_addr}, 32'd9);
`ifdef FETCH_PERF_EN
    chk("async_reset.perf_fetched", perf_fetched, 32'd0);
    chk("async_reset.perf_bubbles", perf_bubbles, 32'd0);
`endif
    cyc(); boot_we = 1'b0;
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Controls the instruction-fetch stage: sequences the PC, owns the instruction-memory port, and issues fetched words to decode with a valid flag.
- Shares the imem port between a boot loader (fill after reset) and run-time fetch.
- Applies hazard stalls, branch/jump redirects (pcsrc) and a halt instruction.
- Uses word addressing throughout: PC advances by 1 per instruction.

Parameters:
- DATA_W, 32, instruction/PC width
- IMEM_DEPTH, 32, instruction memory words (power of 2); ADDR_W = $clog2(IMEM_DEPTH)
- RESET_PC, 0, PC value after reset
- HALT_WORD, 32'hFFFF_FFFF, encoding that stops fetch

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- boot_we  in  1  loader write strobe (honoured in BOOT only)
- boot_addr  in  ADDR_W  loader word address
- boot_data  in  DATA_W  loader write data
- boot_done  in  1  loader finished; leave BOOT
- pcsrc  in  1  redirect request from branch/jump resolution
- branch_target  in  DATA_W  redirect PC (word address)
- stall  in  1  hazard-unit hold
- instr_in  in  DATA_W  imem combinational read data at imem_addr
- imem_addr  out  ADDR_W  imem address
- imem_we  out  1  imem write enable
- imem_wdata  out  DATA_W  imem write data
- pc  out  DATA_W  current fetch PC (registered)
- adder_output  out  DATA_W  PC+1 of the issued instruction (registered)
- instruction  out  DATA_W  issued instruction (registered)
- if_valid  out  1  instruction/adder_output valid for decode
- halted  out  1  high in HALT state

Behaviour:
- Reset (async, rst_n=0):
  - state=BOOT, pc=RESET_PC, adder_output=RESET_PC+1, instruction=0, if_valid=0, halted=0.
  - A reset mid-operation, in any state, returns here immediately.
- States: BOOT=2'd0, RUN=2'd1, HALT=2'd2; 2'd3 is illegal and recovers to BOOT on the next clock.
- imem mux is combinational:
  - In BOOT: imem_addr=boot_addr, imem_we=boot_we, imem_wdata=boot_data.
  - Otherwise: imem_addr=pc[ADDR_W-1:0], imem_we=0, imem_wdata=0.
  - PC values beyond IMEM_DEPTH alias through the low ADDR_W bits.
- BOOT:
  - pc held, if_valid=0.
  - boot_done=1 -> RUN next cycle.
  - boot_we together with boot_done performs the write, then moves to RUN.
- RUN, per clock, with priority pcsrc > stall > halt > normal:
  - pcsrc=1: pc<=branch_target, instruction<=0, if_valid<=0 (one-bubble squash of the word currently addressed); adder_output held. This overrides stall.
  - stall=1 (pcsrc=0): pc, instruction, adder_output and if_valid all hold.
  - instr_in==HALT_WORD: instruction<=instr_in, adder_output<=pc+1, if_valid<=1, pc held, state<=HALT.
  - Normal: instruction<=instr_in, adder_output<=pc+1, pc<=pc+1, if_valid<=1.
- Fetch latency: the word at PC p appears on instruction one clock after pc==p is presented.
- PC arithmetic is modulo 2^DATA_W: 32'hFFFF_FFFF+1 -> 0.
- HALT:
  - halted=1; if_valid<=0 from the first HALT clock onward.
  - pc, instruction and adder_output frozen.
  - pcsrc, stall and boot_* are ignored; exit only via rst_n.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined:
  - Adds outputs perf_fetched [31:0] and perf_bubbles [31:0], both reset to 0.
  - perf_fetched increments on each RUN clock that sets if_valid<=1.
  - perf_bubbles increments on each RUN clock with pcsrc=1 or stall=1.
  - Both saturate at 32'hFFFF_FFFF and are frozen in BOOT and HALT.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Boot fill: write imem[0..2]=32'h11,32'h22,32'h33, then boot_done -> RUN. Over the next three clocks instruction=11,22,33 with if_valid=1, pc=1,2,3 and adder_output=1,2,3.
- Stall: stall=1 for 2 clocks at pc=2 -> pc=2, instruction and adder_output unchanged for 2 clocks; the sequence resumes with 32'h33 afterwards.
- Redirect over stall: pcsrc=1, branch_target=5, stall=1 -> next clock pc=5, if_valid=0, instruction=0. The following clock gives instruction=imem[5], adder_output=6.
- Halt: imem[3]=32'hFFFF_FFFF -> instruction=FFFF_FFFF with if_valid=1 for one clock; then halted=1, if_valid=0, pc=3 frozen. Toggling pcsrc has no effect.
- Alias/wrap: branch_target=33 (IMEM_DEPTH=32) -> imem_addr=1, instruction=imem[1]. branch_target=32'hFFFF_FFFF -> next pc=0.
- Async reset mid-RUN: drop rst_n between clock edges -> outputs immediately return to reset values and state=BOOT. imem_we follows boot_we again; with FETCH_PERF_EN both counters read 0.
